// File: rtl/match_ctrl.sv
// match_ctrl: two-player match sequencer covering serve delay, goal scoring, countdown timer,
// the end-of-match hold and winner decision.
module match_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int SERVE_FRAMES  = 60,
  parameter int OVER_SECONDS  = 3,
  parameter int X_RIGHT       = 640
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       refresh_tick_i,
  input  logic [9:0] ball_x_0_i,
  input  logic [9:0] ball_x_1_i,
  input  logic [3:0] win_score_i,
  input  logic [5:0] match_seconds_i,
  output logic [3:0] score1_o,
  output logic [3:0] score2_o,
  output logic [5:0] seconds_o,
  output logic       new_round_o,
  output logic       game_over_o,
  output logic [1:0] winner_o,
  output logic       done_o
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam int FW = $clog2(SERVE_FRAMES + 1);
  localparam int OW = $clog2(OVER_SECONDS + 1);
  localparam logic [PW-1:0] PT = PW'(TICKS_PER_SEC - 1);
  localparam logic [FW-1:0] FT = FW'(SERVE_FRAMES - 1);
  localparam logic [OW-1:0] OT = OW'(OVER_SECONDS - 1);
  localparam logic [10:0]   XR = 11'(X_RIGHT);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_e;

  state_e        state_q, state_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d, win_q, win_d;
  logic [5:0]    sec_q, sec_d;
  logic [1:0]    winner_q, winner_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] frm_q, frm_d;
  logic [OW-1:0] ocnt_q, ocnt_d;
  logic          done_q, done_d;
  logic          left, right, wrap;

  assign left  = ball_x_0_i == 10'd0 || ball_x_1_i == 10'd0;
  assign right = {1'b0, ball_x_0_i} >= XR || {1'b0, ball_x_1_i} >= XR;
  assign wrap  = presc_q == PT;

  always_comb begin
    state_d  = state_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    win_d    = win_q;
    sec_d    = sec_q;
    winner_d = winner_q;
    presc_d  = presc_q;
    frm_d    = frm_q;
    ocnt_d   = ocnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        win_d    = win_score_i;
        s1_d     = 4'd0;
        s2_d     = 4'd0;
        sec_d    = match_seconds_i;
        winner_d = 2'b00;
        presc_d  = '0;
        frm_d    = '0;
        state_d  = SERVE;
      end
      SERVE: if (refresh_tick_i) begin
        frm_d   = frm_q == FT ? '0 : frm_q + 1'b1;
        state_d = frm_q == FT ? PLAY : SERVE;
      end
      PLAY: begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        sec_d   = sec_q - {5'd0, wrap && sec_q != 6'd0};
        s1_d    = s1_q + {3'd0, right && s1_q != 4'hf};
        s2_d    = s2_q + {3'd0, left && s2_q != 4'hf};
        frm_d   = (left || right) ? '0 : frm_q;
        state_d = (left || right) ? SERVE : PLAY;
      end
      OVER: begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        ocnt_d  = wrap ? ocnt_q + 1'b1 : ocnt_q;
        done_d  = wrap && ocnt_q == OT;
        state_d = done_d ? IDLE : OVER;
      end
      default: state_d = IDLE;
    endcase
    // End-of-match test sees this cycle's goals and tick, so it wins over re-serving
    if ((state_q == SERVE || state_q == PLAY) && (s1_d >= win_q || s2_d >= win_q || sec_d == 6'd0)) begin
      state_d  = OVER;
      presc_d  = '0;
      ocnt_d   = '0;
      winner_d = s1_d > s2_d ? 2'b01 : s2_d > s1_d ? 2'b10 : 2'b11;
    end
    if (abort_i) begin
      state_d  = IDLE;
      s1_d     = s1_q;
      s2_d     = s2_q;
      win_d    = win_q;
      sec_d    = sec_q;
      winner_d = winner_q;
      presc_d  = presc_q;
      ocnt_d   = ocnt_q;
      frm_d    = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      s1_q     <= 4'd0;
      s2_q     <= 4'd0;
      win_q    <= 4'd0;
      sec_q    <= 6'd60;
      winner_q <= 2'b00;
      presc_q  <= '0;
      frm_q    <= '0;
      ocnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      win_q    <= win_d;
      sec_q    <= sec_d;
      winner_q <= winner_d;
      presc_q  <= presc_d;
      frm_q    <= frm_d;
      ocnt_q   <= ocnt_d;
      done_q   <= done_d;
    end
  end

  assign score1_o    = s1_q;
  assign score2_o    = s2_q;
  assign seconds_o   = sec_q;
  assign winner_o    = winner_q;
  assign done_o      = done_q;
  assign new_round_o = state_q != PLAY;
  assign game_over_o = state_q == OVER;
endmodule
